// File: rtl/icache.sv
// Direct-mapped read-only instruction cache; refills one line per miss from the memory controller.
// Define ICACHE_STATS_EN to add saturating hit/miss counter ports.
module icache #(
  parameter int unsigned BLOCK_WIDTH = 1,
  parameter int unsigned CACHE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              rdy_in,
  input  logic                              clear_in,
  input  logic                              IF2IC_en,
  input  logic [ADDR_WIDTH-1:0]             IF2IC_pc,
  output logic                              IC2IF_en,
  output logic [31:0]                       IC2IF_inst,
  output logic                              IC2MC_en,
  output logic [ADDR_WIDTH-1:0]             IC2MC_addr,
  input  logic                              MC2IC_en,
  input  logic [32*(1<<BLOCK_WIDTH)-1:0]    MC2IC_block
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]                       IC_hit_cnt,
  output logic [31:0]                       IC_miss_cnt
`endif
);

  localparam int unsigned BLOCK_SIZE = 1 << BLOCK_WIDTH;
  localparam int unsigned LINE_NUM   = 1 << CACHE_WIDTH;
  localparam int unsigned OFF_WIDTH  = BLOCK_WIDTH + 2;
  localparam int unsigned TAG_WIDTH  = ADDR_WIDTH - CACHE_WIDTH - OFF_WIDTH;

  typedef enum logic {IDLE, MISS} state_t;

  state_t state_q, state_d;
  logic                  drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  if_en_d;
  logic [31:0]           if_inst_d;
  logic                  mc_en_d;
  logic [ADDR_WIDTH-1:0] mc_addr_d;

  logic [BLOCK_SIZE-1:0][31:0] data_mem [LINE_NUM];
  logic [TAG_WIDTH-1:0]        tag_mem  [LINE_NUM];
  logic [LINE_NUM-1:0]         valid_q;

  logic [BLOCK_SIZE-1:0][31:0] mc_words;
  logic [TAG_WIDTH-1:0]        pc_tag, req_tag;
  logic [CACHE_WIDTH-1:0]      pc_idx, req_idx;
  logic [BLOCK_WIDTH-1:0]      pc_word, req_word;
  logic                        accept, hit, fill;
  logic                        unused_ok;

  assign mc_words = MC2IC_block;
  assign pc_tag   = IF2IC_pc[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign pc_idx   = IF2IC_pc[OFF_WIDTH +: CACHE_WIDTH];
  assign pc_word  = IF2IC_pc[2 +: BLOCK_WIDTH];
  assign req_tag  = req_pc_q[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_idx  = req_pc_q[OFF_WIDTH +: CACHE_WIDTH];
  assign req_word = req_pc_q[2 +: BLOCK_WIDTH];
  assign unused_ok = ^{IF2IC_pc[1:0], req_pc_q[1:0]};

  // A flush or a response still on the bus blocks acceptance.
  assign accept = (state_q == IDLE) && IF2IC_en && !IC2IF_en && !clear_in;
  assign hit    = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign fill   = (state_q == MISS) && MC2IC_en;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !hit) state_d = MISS;
      MISS:    if (MC2IC_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_en_d   = 1'b0;
    if_inst_d = IC2IF_inst;
    mc_en_d   = IC2MC_en;
    mc_addr_d = IC2MC_addr;
    req_pc_d  = req_pc_q;
    drop_d    = drop_q;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (accept) begin
          if (hit) begin
            if_en_d   = 1'b1;
            if_inst_d = data_mem[pc_idx][pc_word];
          end else begin
            req_pc_d  = IF2IC_pc;
            mc_en_d   = 1'b1;
            mc_addr_d = {IF2IC_pc[ADDR_WIDTH-1:OFF_WIDTH], OFF_WIDTH'(0)};
          end
        end
      end
      MISS: begin
        if (MC2IC_en) begin
          mc_en_d = 1'b0;
          drop_d  = 1'b0;
          // A flush seen now or earlier in the refill suppresses the response only.
          if (!drop_q && !clear_in) begin
            if_en_d   = 1'b1;
            if_inst_d = mc_words[req_word];
          end
        end else if (clear_in) begin
          drop_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      IC2IF_en   <= 1'b0;
      IC2IF_inst <= '0;
      IC2MC_en   <= 1'b0;
      IC2MC_addr <= '0;
      req_pc_q   <= '0;
      drop_q     <= 1'b0;
      valid_q    <= '0;
    end else if (rdy_in) begin
      IC2IF_en   <= if_en_d;
      IC2IF_inst <= if_inst_d;
      IC2MC_en   <= mc_en_d;
      IC2MC_addr <= mc_addr_d;
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
      if (fill) valid_q[req_idx] <= 1'b1;
    end
  end

  // Line storage carries no reset; the valid bits guard it.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && fill) begin
      data_mem[req_idx] <= mc_words;
      tag_mem[req_idx]  <= req_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      IC_hit_cnt  <= '0;
      IC_miss_cnt <= '0;
    end else if (rdy_in && accept) begin
      if (hit) begin
        if (IC_hit_cnt != 32'hFFFF_FFFF) IC_hit_cnt <= IC_hit_cnt + 32'd1;
      end else begin
        if (IC_miss_cnt != 32'hFFFF_FFFF) IC_miss_cnt <= IC_miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
